alu_seq_unit: RTL and testbench

Parametrised, registered successor to the lab combinational ALU. It adds a valid/ready input handshake and a registered result with a one-cycle done pulse. Multiplication and division/modulus run iteratively (shift-add and restoring), so width N scales without large combinational arrays. It sits between the operand/opcode capture logic and the BCD/7-segment display path, which consumes result_o and the flags.

---
 rtl/alu_seq_unit.sv | 261 ++++++++++++++++++++++++++
 tb/tb_alu_seq_unit.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/alu_seq_unit.sv
`default_nettype none
// ============================================================================
//  Module   : alu_seq_unit
//  Purpose  : Registered ALU with a valid/ready input handshake and a
//             one-cycle done pulse. ADD/SUB/logic/shift ops complete in one
//             cycle. MUL runs as an iterative shift-add. DIV/MOD run as an
//             iterative restoring divider, so the datapath stays narrow for
//             any NBIT.
//  Ports    : clk, rst_n         - clock, asynchronous active-low reset
//             in_valid_i/in_ready_o - operand handshake (ready only in IDLE)
//             a_i, b_i, op_i     - operands and opcode
//                                  (0 ADD,1 SUB,2 MUL,3 DIV,4 MOD,5 AND,
//                                   6 OR,7 XOR,8 SHL,9 SHR)
//             out_valid_o        - one-cycle pulse when result/flags update
//             result_o, n_o, z_o, c_o, v_o - registered result and flags
//             err_o              - divide-by-zero flag (only with macro)
//  Options  : `define ALU_DIVZERO_ERR_EN adds the err_o output
//  Revision : 1.0 - initial release
// ============================================================================
module alu_seq_unit #(
    parameter int NBIT = 4,
    parameter int SHW  = $clog2(NBIT)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid_i,
    output logic            in_ready_o,
    input  logic [NBIT-1:0] a_i,
    input  logic [NBIT-1:0] b_i,
    input  logic [3:0]      op_i,
    output logic            out_valid_o,
    output logic [NBIT-1:0] result_o,
    output logic            n_o,
    output logic            z_o,
    output logic            c_o,
    output logic            v_o
`ifdef ALU_DIVZERO_ERR_EN
    ,output logic           err_o
`endif
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam logic [3:0] c_OP_ADD = 4'd0;
    localparam logic [3:0] c_OP_SUB = 4'd1;
    localparam logic [3:0] c_OP_MUL = 4'd2;
    localparam logic [3:0] c_OP_DIV = 4'd3;
    localparam logic [3:0] c_OP_MOD = 4'd4;
    localparam logic [3:0] c_OP_AND = 4'd5;
    localparam logic [3:0] c_OP_OR  = 4'd6;
    localparam logic [3:0] c_OP_XOR = 4'd7;
    localparam logic [3:0] c_OP_SHL = 4'd8;
    localparam logic [3:0] c_OP_SHR = 4'd9;
    localparam logic [NBIT:0] c_NBIT_EXT = (NBIT+1)'(NBIT);

    state_t            r_state, w_state_nxt;
    logic [SHW-1:0]    r_cnt;
    logic [NBIT-1:0]   r_hi;        // MUL: partial-product high half; DIV: remainder
    logic [NBIT-1:0]   r_lo;        // MUL: multiplier/product low half; DIV: dividend/quotient
    logic [NBIT-1:0]   r_b;
    logic              r_is_mod;
    logic [NBIT-1:0]   r_result;
    logic              r_n, r_z, r_c, r_v;

    logic              w_accept;
    logic              w_b_zero;
    logic              w_load;
    logic [NBIT-1:0]   w_res_nxt;
    logic              w_c_nxt, w_v_nxt;

    // ---------------- single-cycle datapath (operates on the accept edge) ----
    logic [NBIT:0]     w_add, w_sub, w_shl, w_shr;
    logic              w_sh_big;
    logic [NBIT-1:0]   w_s_res;
    logic              w_s_c, w_s_v;

    assign w_accept = in_valid_i && (r_state == S_IDLE);
    assign w_b_zero = (b_i == '0);
    assign w_add    = {1'b0, a_i} + {1'b0, b_i};
    assign w_sub    = {1'b0, a_i} - {1'b0, b_i};
    // Extra bit on the far side of each shift captures the last bit shifted out.
    assign w_shl    = {1'b0, a_i} << b_i[SHW-1:0];
    assign w_shr    = {a_i, 1'b0} >> b_i[SHW-1:0];
    assign w_sh_big = ({1'b0, b_i} >= c_NBIT_EXT);

    always_comb begin
        w_s_res = '0;
        w_s_c   = 1'b0;
        w_s_v   = 1'b0;
        case (op_i)
            c_OP_ADD: begin
                w_s_res = w_add[NBIT-1:0];
                w_s_c   = w_add[NBIT];
                w_s_v   = (a_i[NBIT-1] == b_i[NBIT-1]) && (w_add[NBIT-1] != a_i[NBIT-1]);
            end
            c_OP_SUB: begin
                w_s_res = w_sub[NBIT-1:0];
                w_s_c   = ~w_sub[NBIT];          // no-borrow
                w_s_v   = (a_i[NBIT-1] != b_i[NBIT-1]) && (w_sub[NBIT-1] != a_i[NBIT-1]);
            end
            c_OP_AND: w_s_res = a_i & b_i;
            c_OP_OR:  w_s_res = a_i | b_i;
            c_OP_XOR: w_s_res = a_i ^ b_i;
            c_OP_SHL: begin
                if (!w_sh_big) begin
                    w_s_res = w_shl[NBIT-1:0];
                    w_s_c   = w_shl[NBIT];
                end
            end
            c_OP_SHR: begin
                if (!w_sh_big) begin
                    w_s_res = w_shr[NBIT:1];
                    w_s_c   = w_shr[0];
                end
            end
            // DIV/MOD reach here only with b=0; undefined opcodes also give 0.
            default: w_s_res = '0;
        endcase
    end

    // ---------------- iterative datapath ------------------------------------
    logic [NBIT:0]     w_mul_sum;
    logic [NBIT-1:0]   w_mul_hi, w_mul_lo;
    logic [NBIT:0]     w_div_sh, w_div_diff;
    logic              w_div_ok;
    logic [NBIT-1:0]   w_div_hi, w_div_lo;

    // Shift-add: add multiplicand into the high half when the current
    // multiplier bit is set, then shift the whole {carry,hi,lo} right.
    assign w_mul_sum  = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_b} : '0);
    assign w_mul_hi   = w_mul_sum[NBIT:1];
    assign w_mul_lo   = {w_mul_sum[0], r_lo[NBIT-1:1]};

    // Restoring step: shift next dividend bit into the remainder, keep the
    // subtraction only if it did not borrow.
    assign w_div_sh   = {r_hi, r_lo[NBIT-1]};
    assign w_div_diff = w_div_sh - {1'b0, r_b};
    assign w_div_ok   = ~w_div_diff[NBIT];
    assign w_div_hi   = w_div_ok ? w_div_diff[NBIT-1:0] : w_div_sh[NBIT-1:0];
    assign w_div_lo   = {r_lo[NBIT-2:0], w_div_ok};

    // ---------------- FSM ----------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_res_nxt   = w_s_res;
        w_c_nxt     = w_s_c;
        w_v_nxt     = w_s_v;
        unique case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    if (op_i == c_OP_MUL) begin
                        w_state_nxt = S_MUL;
                    end else if (((op_i == c_OP_DIV) || (op_i == c_OP_MOD)) && !w_b_zero) begin
                        w_state_nxt = S_DIV;
                    end else begin
                        w_state_nxt = S_DONE;
                        w_load      = 1'b1;
                    end
                end
            end
            S_MUL: begin
                if (r_cnt == '0) begin
                    w_state_nxt = S_DONE;
                    w_load      = 1'b1;
                    w_res_nxt   = w_mul_lo;
                    w_c_nxt     = 1'b0;
                    w_v_nxt     = |w_mul_hi;
                end
            end
            S_DIV: begin
                if (r_cnt == '0) begin
                    w_state_nxt = S_DONE;
                    w_load      = 1'b1;
                    w_res_nxt   = r_is_mod ? w_div_hi : w_div_lo;
                    w_c_nxt     = 1'b0;
                    w_v_nxt     = 1'b0;
                end
            end
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // ---------------- operand / iteration registers --------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt    <= '0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_b      <= '0;
            r_is_mod <= 1'b0;
        end else if (w_accept) begin
            r_cnt    <= SHW'(NBIT-1);
            r_hi     <= '0;
            r_lo     <= a_i;
            r_b      <= b_i;
            r_is_mod <= (op_i == c_OP_MOD);
        end else if (r_state == S_MUL) begin
            r_cnt    <= r_cnt - 1'b1;
            r_hi     <= w_mul_hi;
            r_lo     <= w_mul_lo;
        end else if (r_state == S_DIV) begin
            r_cnt    <= r_cnt - 1'b1;
            r_hi     <= w_div_hi;
            r_lo     <= w_div_lo;
        end
    end

    // ---------------- result / flag registers --------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_result <= '0;
            r_n      <= 1'b0;
            r_z      <= 1'b0;
            r_c      <= 1'b0;
            r_v      <= 1'b0;
        end else if (w_load) begin
            r_result <= w_res_nxt;
            r_n      <= w_res_nxt[NBIT-1];
            r_z      <= (w_res_nxt == '0);
            r_c      <= w_c_nxt;
            r_v      <= w_v_nxt;
        end
    end

`ifdef ALU_DIVZERO_ERR_EN
    logic r_err;
    logic w_s_err;

    // Only a direct IDLE->DONE load can be a divide by zero.
    assign w_s_err = ((op_i == c_OP_DIV) || (op_i == c_OP_MOD)) && w_b_zero;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      r_err <= 1'b0;
        else if (w_load) r_err <= (r_state == S_IDLE) ? w_s_err : 1'b0;
    end

    assign err_o = r_err;
`endif

    assign in_ready_o  = (r_state == S_IDLE);
    assign out_valid_o = (r_state == S_DONE);
    assign result_o    = r_result;
    assign n_o         = r_n;
    assign z_o         = r_z;
    assign c_o         = r_c;
    assign v_o         = r_v;

endmodule
`default_nettype wire

// File: tb/tb_alu_seq_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_alu_seq_unit
//  Purpose  : Directed self-checking bench for alu_seq_unit at NBIT=4.
//             Expected values are hand-computed constants.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_alu_seq_unit;

    logic       clk;
    logic       rst_n;
    logic       in_valid_i;
    logic       in_ready_o;
    logic [3:0] a_i;
    logic [3:0] b_i;
    logic [3:0] op_i;
    logic       out_valid_o;
    logic [3:0] result_o;
    logic       n_o, z_o, c_o, v_o;
`ifdef ALU_DIVZERO_ERR_EN
    logic       err_o;
`endif

    int n_vec = 0;
    int n_err = 0;

    alu_seq_unit #(.NBIT(4)) u_dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .a_i         (a_i),
        .b_i         (b_i),
        .op_i        (op_i),
        .out_valid_o (out_valid_o),
        .result_o    (result_o),
        .n_o         (n_o),
        .z_o         (z_o),
        .c_o         (c_o),
        .v_o         (v_o)
`ifdef ALU_DIVZERO_ERR_EN
        ,.err_o      (err_o)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Apply one op, measure accept-to-out_valid latency, check result and
    // flags {N,Z,C,V}, then check the done pulse lasts one cycle.
    task automatic run_op(input string tag, input logic [3:0] op, input logic [3:0] a,
                          input logic [3:0] b, input int exp_lat, input logic [3:0] exp_res,
                          input logic [3:0] exp_f, input logic exp_err);
        int lat;
        @(negedge clk);
        chk({tag, "_rdy"}, 32'(in_ready_o), 32'd1);
        op_i = op; a_i = a; b_i = b; in_valid_i = 1'b1;
        @(posedge clk); #1;
        // Scramble inputs: the DUT must have latched them already.
        in_valid_i = 1'b0; op_i = 4'hF; a_i = ~a; b_i = ~b;
        lat = 1;
        while (!out_valid_o && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        chk({tag, "_res"}, 32'(result_o), 32'(exp_res));
        chk({tag, "_nzcv"}, 32'({n_o, z_o, c_o, v_o}), 32'(exp_f));
`ifdef ALU_DIVZERO_ERR_EN
        chk({tag, "_err"}, 32'(err_o), 32'(exp_err));
`else
        if (exp_err) begin end
`endif
        @(posedge clk); #1;
        chk({tag, "_pulse"}, 32'(out_valid_o), 32'd0);
        chk({tag, "_hold"}, 32'(result_o), 32'(exp_res));
    endtask

    initial begin
        int cyc;
        int busy;
        int seen;
        rst_n = 1'b0; in_valid_i = 1'b0; a_i = '0; b_i = '0; op_i = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_rdy",   32'(in_ready_o), 32'd1);
        chk("rst_vld",   32'(out_valid_o), 32'd0);
        chk("rst_res",   32'(result_o), 32'd0);
        chk("rst_flags", 32'({n_o, z_o, c_o, v_o}), 32'd0);
        @(negedge clk); rst_n = 1'b1;

        //       tag       op     a      b     lat res    NZCV     err
        run_op("add9_8",  4'd0, 4'd9,  4'd8,  1, 4'd1,  4'b0011, 1'b0);
        run_op("add7_1",  4'd0, 4'd7,  4'd1,  1, 4'd8,  4'b1001, 1'b0);
        run_op("sub3_5",  4'd1, 4'd3,  4'd5,  1, 4'd14, 4'b1000, 1'b0);
        run_op("sub5_5",  4'd1, 4'd5,  4'd5,  1, 4'd0,  4'b0110, 1'b0);
        run_op("mul7_3",  4'd2, 4'd7,  4'd3,  5, 4'd5,  4'b0001, 1'b0);
        run_op("mul3_2",  4'd2, 4'd3,  4'd2,  5, 4'd6,  4'b0000, 1'b0);
        run_op("mulF_F",  4'd2, 4'd15, 4'd15, 5, 4'd1,  4'b0001, 1'b0);
        run_op("div13_4", 4'd3, 4'd13, 4'd4,  5, 4'd3,  4'b0000, 1'b0);
        run_op("mod13_4", 4'd4, 4'd13, 4'd4,  5, 4'd1,  4'b0000, 1'b0);
        run_op("divF_1",  4'd3, 4'd15, 4'd1,  5, 4'd15, 4'b1000, 1'b0);
        run_op("div9_0",  4'd3, 4'd9,  4'd0,  1, 4'd0,  4'b0100, 1'b1);
        run_op("mod7_0",  4'd4, 4'd7,  4'd0,  1, 4'd0,  4'b0100, 1'b1);
        run_op("and",     4'd5, 4'd12, 4'd10, 1, 4'd8,  4'b1000, 1'b0);
        run_op("or",      4'd6, 4'd5,  4'd10, 1, 4'd15, 4'b1000, 1'b0);
        run_op("xor",     4'd7, 4'd15, 4'd15, 1, 4'd0,  4'b0100, 1'b0);
        run_op("shl1",    4'd8, 4'b1011, 4'd1, 1, 4'b0110, 4'b0010, 1'b0);
        run_op("shl0",    4'd8, 4'b1011, 4'd0, 1, 4'b1011, 4'b1000, 1'b0);
        run_op("shr2",    4'd9, 4'b1011, 4'd2, 1, 4'b0010, 4'b0010, 1'b0);
        run_op("shr4",    4'd9, 4'b1011, 4'd4, 1, 4'd0,  4'b0100, 1'b0);
        run_op("op12",    4'd12, 4'd7, 4'd3,  1, 4'd0,  4'b0100, 1'b0);

        // in_valid_i held high: MUL then ADD; ADD must wait for MUL's DONE.
        @(negedge clk);
        op_i = 4'd2; a_i = 4'd2; b_i = 4'd3; in_valid_i = 1'b1;
        @(posedge clk); #1;
        op_i = 4'd0; a_i = 4'd1; b_i = 4'd1;
        cyc = 1; busy = 0;
        while (!out_valid_o && cyc < 20) begin
            if (!in_ready_o) busy++;
            @(posedge clk); #1;
            cyc++;
        end
        if (!in_ready_o) busy++;
        chk("hold_mul_lat", 32'(cyc), 32'd5);
        chk("hold_mul_busy", 32'(busy), 32'd5);
        chk("hold_mul_res", 32'(result_o), 32'd6);
        @(posedge clk); #1;
        chk("hold_idle_rdy", 32'(in_ready_o), 32'd1);
        chk("hold_idle_vld", 32'(out_valid_o), 32'd0);
        @(posedge clk); #1;
        chk("hold_add_vld", 32'(out_valid_o), 32'd1);
        chk("hold_add_res", 32'(result_o), 32'd2);
        in_valid_i = 1'b0;
        @(posedge clk); #1;

        // Reset in the 2nd DIV cycle aborts the op with no done pulse.
        @(negedge clk);
        op_i = 4'd3; a_i = 4'd13; b_i = 4'd4; in_valid_i = 1'b1;
        @(posedge clk); #1;
        in_valid_i = 1'b0;
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        chk("abort_rdy", 32'(in_ready_o), 32'd1);
        chk("abort_vld", 32'(out_valid_o), 32'd0);
        chk("abort_res", 32'(result_o), 32'd0);
        chk("abort_flags", 32'({n_o, z_o, c_o, v_o}), 32'd0);
        @(negedge clk); rst_n = 1'b1;
        seen = 0;
        repeat (8) begin
            @(posedge clk); #1;
            if (out_valid_o) seen++;
        end
        chk("abort_no_pulse", 32'(seen), 32'd0);
        run_op("post_add", 4'd0, 4'd2, 4'd3, 1, 4'd5, 4'b0000, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
